// File: rtl/noc_write_arbiter.sv
// Round-robin arbiter for the shared write bus feeding the bus_repeater tree; one beat per cycle, bursts of up to MAX_BURST.
// Latency: valid->ready 1 cycle from IDLE, ready->bus 1 cycle. Optional counters under NOC_ARB_STATS_EN.
module noc_write_arbiter #(
    parameter int                N_REQ     = 4,
    parameter int                WB_WID    = 32,
    parameter int                MAX_BURST = 4,
    parameter logic [WB_WID-1:0] IDLE_ADR  = 32'hFFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WB_WID-1:0] req_dat,
    input  logic [N_REQ*WB_WID-1:0] req_adr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [WB_WID-1:0]       bus_dat,
    output logic [WB_WID-1:0]       bus_adr,
    output logic [N_REQ-1:0]        grant
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [31:0]             stat_beats,
    output logic [31:0]             stat_grants
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_REQ_EXT = (PTR_W + 1)'(N_REQ);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_cnt_nxt;
    logic [WB_WID-1:0]  r_bus_dat, r_bus_adr;
    logic [WB_WID-1:0]  w_dat_arr [N_REQ];
    logic [WB_WID-1:0]  w_adr_arr [N_REQ];
    logic               w_pick_vld, w_accept, w_new_grant;
    logic [PTR_W-1:0]   w_pick;
`ifdef NOC_ARB_STATS_EN
    logic [31:0]        r_stat_beats, r_stat_grants;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_dat_arr[g] = req_dat[g*WB_WID +: WB_WID];
        assign w_adr_arr[g] = req_adr[g*WB_WID +: WB_WID];
    end

    // Descending scan so the smallest offset from rr_ptr is the one left standing.
    always_comb begin
        logic [PTR_W:0] w_sum;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_sum      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= N_REQ_EXT) w_sum = w_sum - N_REQ_EXT;
            if (req_valid[w_sum[PTR_W-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_sum[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_bus_dat  <= '0;
            r_bus_adr  <= IDLE_ADR;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_bus_dat  <= w_accept ? w_dat_arr[r_owner] : '0;
            r_bus_adr  <= w_accept ? w_adr_arr[r_owner] : IDLE_ADR;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_beat_cnt;
        w_new_grant = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt         = S_BURST;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_owner_nxt         = w_pick;
                    w_cnt_nxt           = '0;
                    w_new_grant         = 1'b1;
                end
            end
            S_BURST: begin
                // Owner dropping valid forfeits the grant just like a completed burst.
                if (!w_accept || r_beat_cnt == LAST_BEAT) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_rr_nxt    = (r_owner == LAST_REQ) ? '0 : r_owner + 1'b1;
                end else begin
                    w_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        w_accept  = 1'b0;
        if (r_state == S_BURST) begin
            req_ready[r_owner] = req_valid[r_owner];
            w_accept           = req_valid[r_owner];
        end
    end

    assign bus_dat = r_bus_dat;
    assign bus_adr = r_bus_adr;
    assign grant   = r_grant;

`ifdef NOC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_beats  <= '0;
            r_stat_grants <= '0;
        end else begin
            r_stat_beats  <= r_stat_beats  + 32'(w_accept);
            r_stat_grants <= r_stat_grants + 32'(w_new_grant);
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_grants = r_stat_grants;
`endif

endmodule

// File: tb/tb_noc_write_arbiter.sv
// Bench for noc_write_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_noc_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   req_valid, req_ready, grant;
    logic [N*W-1:0] req_dat, req_adr;
    logic [W-1:0]   bus_dat, bus_adr;
`ifdef NOC_ARB_STATS_EN
    logic [31:0]    stat_beats, stat_grants;
`endif

    noc_write_arbiter #(.N_REQ(N), .WB_WID(W), .MAX_BURST(MB), .IDLE_ADR(IDLE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dat(req_dat), .req_adr(req_adr),
        .req_ready(req_ready), .bus_dat(bus_dat), .bus_adr(bus_adr), .grant(grant)
`ifdef NOC_ARB_STATS_EN
        , .stat_beats(stat_beats), .stat_grants(stat_grants)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-requester beat lists: each requester streams its list in order.
    logic [31:0] b_dat [N][64];
    logic [31:0] b_adr [N][64];
    int          hd [N];
    int          nb [N];
    logic [N-1:0] gate = '1;

    // Model: owner -1 means nobody holds the bus; beats_left counts down the burst.
    int          m_owner = -1;
    int          m_left  = 0;
    int          m_ptr   = 0;
    logic [31:0] m_dat   = '0;
    logic [31:0] m_adr   = IDLE;
    logic [31:0] m_beats = '0;
    logic [31:0] m_grants = '0;

    logic [31:0] log_adr [$];
    logic [3:0]  log_gnt [$];
    logic [3:0]  tr [$];

    task automatic load(input int i, input int n, input logic [31:0] a0);
        hd[i] = 0;
        nb[i] = n;
        for (int k = 0; k < n; k++) begin
            b_adr[i][k] = a0 + 32'(k);
            b_dat[i][k] = $urandom;
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            nb[i] = 0;
        end
        gate = '1;
        log_adr.delete();
        log_gnt.delete();
    endtask

    task automatic cycle(input bit r);
        logic [N-1:0] v;
        logic [N-1:0] er;
        logic [N-1:0] eg;
        bit found;
        int o;
        rst = r;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (hd[i] < nb[i]) begin
                v[i] = gate[i];
                req_dat[i*W +: W] = b_dat[i][hd[i]];
                req_adr[i*W +: W] = b_adr[i][hd[i]];
            end else begin
                req_dat[i*W +: W] = $urandom;
                req_adr[i*W +: W] = $urandom;
            end
        end
        req_valid = v;
        er = '0;
        if (m_owner >= 0) er[m_owner] = v[m_owner];
        #1;
        chk("ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        if (r) begin
            m_owner = -1; m_left = 0; m_ptr = 0;
            m_dat = '0; m_adr = IDLE; m_beats = '0; m_grants = '0;
        end else if (m_owner < 0) begin
            m_dat = '0;
            m_adr = IDLE;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                o = (m_ptr + k) % N;
                if (!found && v[o]) begin
                    found = 1'b1;
                    m_owner = o;
                end
            end
            if (found) begin
                m_left = MB;
                m_grants++;
            end
        end else begin
            o = m_owner;
            if (v[o]) begin
                m_dat = b_dat[o][hd[o]];
                m_adr = b_adr[o][hd[o]];
                hd[o]++;
                m_beats++;
                m_left--;
                if (m_left == 0) begin
                    m_ptr = (o + 1) % N;
                    m_owner = -1;
                end
            end else begin
                m_dat = '0;
                m_adr = IDLE;
                m_ptr = (o + 1) % N;
                m_owner = -1;
            end
        end
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        chk("bus_dat", bus_dat, m_dat);
        chk("bus_adr", bus_adr, m_adr);
`ifdef NOC_ARB_STATS_EN
        chk("stat_beats", stat_beats, m_beats);
        chk("stat_grants", stat_grants, m_grants);
`endif
        log_adr.push_back(bus_adr);
        log_gnt.push_back(grant);
    endtask

    // Ordered list of grants as they start; compared against nibbles of seq (first grant in seq[3:0]).
    task automatic chk_trans(input string tag, input logic [31:0] seq, input int n);
        tr.delete();
        for (int k = 0; k < log_gnt.size(); k++)
            if (log_gnt[k] != 0 && (k == 0 || log_gnt[k-1] == 0)) tr.push_back(log_gnt[k]);
        chk({tag, "_cnt"}, 32'(tr.size()), 32'(n));
        for (int j = 0; j < n && j < tr.size(); j++)
            chk(tag, 32'(tr[j]), 32'(seq[j*4 +: 4]));
    endtask

    initial begin
        logic [31:0] exp_adr [7];
        int first;
        int beats;
        exp_adr = '{32'h10, 32'h11, 32'h12, 32'h13, IDLE, 32'h14, 32'h15};
        for (int i = 0; i < N; i++) begin hd[i] = 0; nb[i] = 0; end
        rst = 1'b1;
        req_valid = '0;
        req_dat = '0;
        req_adr = '0;
        @(posedge clk);
        #1;

        // Reset values
        cycle(1);
        cycle(1);
        chk("rst_adr", bus_adr, IDLE);
        chk("rst_dat", bus_dat, 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);

        // Single requester: 4-beat burst, one bubble, remaining 2 beats
        clr();
        load(0, 6, 32'h10);
        for (int c = 0; c < 14; c++) cycle(0);
        first = -1;
        for (int k = log_adr.size() - 1; k >= 0; k--) if (log_adr[k] != IDLE) first = k;
        chk("single_first", 32'(first), 32'd1);
        if (first >= 0) begin
            chk("single_gnt", 32'(log_gnt[first]), 32'h1);
            for (int j = 0; j < 7 && first + j < log_adr.size(); j++)
                chk("single_seq", log_adr[first + j], exp_adr[j]);
        end

        // All four continuously valid: round-robin order, 4 beats per grant
        cycle(1);
        clr();
        for (int i = 0; i < N; i++) load(i, 8, 32'(i) << 8);
        for (int c = 0; c < 45; c++) cycle(0);
        chk_trans("rr_order", 32'h8421_8421, 8);
        beats = 0;
        foreach (log_adr[k]) if (log_adr[k] != IDLE) beats++;
        chk("rr_beats", 32'(beats), 32'd32);

        // Requester 2 quits after 2 beats; requester 3 follows
        cycle(1);
        clr();
        load(2, 2, 32'h200);
        load(3, 4, 32'h300);
        for (int c = 0; c < 15; c++) cycle(0);
        chk_trans("drop_order", 32'h0000_0084, 2);

        // Reset asserted during the second beat of a burst
        cycle(1);
        clr();
        load(0, 6, 32'h100);
        cycle(0);
        cycle(0);
        cycle(1);
        chk("rstmid_grant", 32'(grant), 32'h0);
        chk("rstmid_adr", bus_adr, IDLE);
        chk("rstmid_dat", bus_dat, 32'h0);
        cycle(0);
        chk("rstmid_bus", bus_adr, IDLE);

`ifdef NOC_ARB_STATS_EN
        cycle(1);
        clr();
        load(1, 12, 32'h500);
        for (int c = 0; c < 20; c++) cycle(0);
        chk("stats_beats12", stat_beats, 32'd12);
        chk("stats_grants3", stat_grants, 32'd3);
        cycle(1);
        chk("stats_rst_b", stat_beats, 32'd0);
        chk("stats_rst_g", stat_grants, 32'd0);
`endif

        // Randomized traffic with valid gaps and occasional reset
        cycle(1);
        clr();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hd[i] >= nb[i] && $urandom_range(3) == 0)
                    load(i, $urandom_range(6, 1), $urandom & 32'h0FFF_FFF0);
                gate[i] = ($urandom_range(7) != 0);
            end
            cycle($urandom_range(199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
